// File: rtl/dcache_ctrl.sv
// Control FSM for the 2-way, 16-set, 32-byte-line write-back, write-allocate data cache.
// Serves hits with zero stall; on a miss it writes back a dirty victim and refills the line.
module dcache_ctrl #(
  parameter int ADDR_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              cpu_req_i,
  input  logic              cpu_write_i,
  input  logic [ADDR_W-1:0] cpu_addr_i,
  input  logic [31:0]       cpu_data_i,
  output logic [31:0]       cpu_data_o,
  output logic              cpu_stall_o,
  output logic              sram_enable_o,
  output logic              sram_write_o,
  output logic [3:0]        sram_addr_o,
  output logic [ADDR_W-8:0] sram_tag_o,
  output logic [255:0]      sram_data_o,
  input  logic [ADDR_W-8:0] sram_tag_i,
  input  logic [255:0]      sram_data_i,
  input  logic              sram_hit_i,
  output logic              mem_enable_o,
  output logic              mem_write_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [255:0]      mem_data_o,
  input  logic [255:0]      mem_data_i,
  input  logic              mem_ack_i
);

  localparam int TAG_W = ADDR_W - 9;

  typedef enum logic [2:0] {
    IDLE,
    MISS,
    WRITEBACK,
    READMISS,
    READMISSOK
  } state_t;

  state_t state_q, state_d;

  logic              mem_enable_d, mem_write_d;
  logic [ADDR_W-1:0] mem_addr_d;
  logic [255:0]      mem_data_d;

  logic [TAG_W-1:0]  cpu_tag;
  logic [7:0]        word_lsb;
  logic [ADDR_W-1:0] refill_addr;
  logic              addr_lsb_unused;

  assign cpu_tag         = cpu_addr_i[ADDR_W-1:9];
  assign word_lsb        = {cpu_addr_i[4:2], 5'd0};
  assign refill_addr     = {cpu_addr_i[ADDR_W-1:5], 5'd0};
  assign addr_lsb_unused = &{1'b0, cpu_addr_i[1:0]};

  assign sram_addr_o = cpu_addr_i[8:5];
  assign cpu_stall_o = (state_q != IDLE) || (cpu_req_i && !sram_hit_i);

  always_comb begin
    // NOTE: every output and next-state value gets a default first so no path infers a latch.
    state_d       = state_q;
    mem_enable_d  = mem_enable_o;
    mem_write_d   = mem_write_o;
    mem_addr_d    = mem_addr_o;
    mem_data_d    = mem_data_o;
    sram_enable_o = 1'b1;
    sram_write_o  = 1'b0;
    sram_tag_o    = {1'b1, 1'b0, cpu_tag};
    sram_data_o   = '0;
    cpu_data_o    = '0;

    unique case (state_q)
      IDLE: begin
        sram_enable_o = cpu_req_i;
        if (cpu_req_i) begin
          if (sram_hit_i) begin
            if (cpu_write_i) begin
              sram_write_o                = 1'b1;
              sram_tag_o                  = {1'b1, 1'b1, cpu_tag};
              sram_data_o                 = sram_data_i;
              sram_data_o[word_lsb +: 32] = cpu_data_i;
            end else begin
              cpu_data_o = sram_data_i[word_lsb +: 32];
            end
          end else begin
            state_d = MISS;
          end
        end
      end
      MISS: begin
        // The SRAM presents the LRU victim while the lookup misses.
        mem_enable_d = 1'b1;
        if (sram_tag_i[TAG_W+1] && sram_tag_i[TAG_W]) begin
          state_d     = WRITEBACK;
          mem_write_d = 1'b1;
          mem_addr_d  = {sram_tag_i[TAG_W-1:0], cpu_addr_i[8:5], 5'd0};
          mem_data_d  = sram_data_i;
        end else begin
          state_d     = READMISS;
          mem_write_d = 1'b0;
          mem_addr_d  = refill_addr;
        end
      end
      WRITEBACK: begin
        if (mem_ack_i) begin
          state_d     = READMISS;
          mem_write_d = 1'b0;
          mem_addr_d  = refill_addr;
        end
      end
      READMISS: begin
        if (mem_ack_i) begin
          state_d      = READMISSOK;
          sram_write_o = 1'b1;
          sram_tag_o   = {1'b1, 1'b0, cpu_tag};
          sram_data_o  = mem_data_i;
          mem_enable_d = 1'b0;
        end
      end
      READMISSOK: state_d = IDLE;
      default:    state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q      <= IDLE;
      mem_enable_o <= 1'b0;
      mem_write_o  <= 1'b0;
      mem_addr_o   <= '0;
      mem_data_o   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      state_q      <= state_d;
      mem_enable_o <= mem_enable_d;
      mem_write_o  <= mem_write_d;
      mem_addr_o   <= mem_addr_d;
      mem_data_o   <= mem_data_d;
    end
  end

endmodule

// File: tb/tb_dcache_ctrl.sv
// Bench for dcache_ctrl: behavioural 2-way SRAM and line memory around the DUT,
// checked against an architectural memory image plus a per-set recency model.
module tb_dcache_ctrl;

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic          cpu_req_i, cpu_write_i;
  logic [31:0]   cpu_addr_i, cpu_data_i, cpu_data_o;
  logic          cpu_stall_o;
  logic          sram_enable_o, sram_write_o;
  logic [3:0]    sram_addr_o;
  logic [24:0]   sram_tag_o, sram_tag_i;
  logic [255:0]  sram_data_o, sram_data_i;
  logic          sram_hit_i;
  logic          mem_enable_o, mem_write_o;
  logic [31:0]   mem_addr_o;
  logic [255:0]  mem_data_o, mem_data_i;
  logic          mem_ack_i;

  int checks = 0;
  int errors = 0;

  always #5 clk_i = ~clk_i;

  dcache_ctrl #(.ADDR_W(32)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .cpu_req_i(cpu_req_i), .cpu_write_i(cpu_write_i), .cpu_addr_i(cpu_addr_i),
    .cpu_data_i(cpu_data_i), .cpu_data_o(cpu_data_o), .cpu_stall_o(cpu_stall_o),
    .sram_enable_o(sram_enable_o), .sram_write_o(sram_write_o), .sram_addr_o(sram_addr_o),
    .sram_tag_o(sram_tag_o), .sram_data_o(sram_data_o), .sram_tag_i(sram_tag_i),
    .sram_data_i(sram_data_i), .sram_hit_i(sram_hit_i),
    .mem_enable_o(mem_enable_o), .mem_write_o(mem_write_o), .mem_addr_o(mem_addr_o),
    .mem_data_o(mem_data_o), .mem_data_i(mem_data_i), .mem_ack_i(mem_ack_i)
  );

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Tag/data array: 2 ways per set, LRU victim shown on a miss.
  logic [24:0]  s_tag  [16][2] = '{default: '0};
  logic [255:0] s_data [16][2] = '{default: '0};
  logic         s_lru  [16]    = '{default: 1'b0};
  logic         h0, h1, s_way;

  always_comb begin
    h0 = s_tag[sram_addr_o][0][24] && (s_tag[sram_addr_o][0][22:0] == sram_tag_o[22:0]);
    h1 = s_tag[sram_addr_o][1][24] && (s_tag[sram_addr_o][1][22:0] == sram_tag_o[22:0]);
    s_way       = h0 ? 1'b0 : (h1 ? 1'b1 : s_lru[sram_addr_o]);
    sram_hit_i  = h0 | h1;
    sram_tag_i  = s_tag[sram_addr_o][s_way];
    sram_data_i = s_data[sram_addr_o][s_way];
  end

  always @(posedge clk_i) begin
    if (sram_enable_o) begin
      if (sram_write_o) begin
        s_tag[sram_addr_o][s_way]  <= sram_tag_o;
        s_data[sram_addr_o][s_way] <= sram_data_o;
      end
      if (sram_hit_i || sram_write_o) s_lru[sram_addr_o] <= ~s_way;
    end
  end

  function automatic logic [24:0] sram_find_tag(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (s_tag[a[8:5]][w][24] && s_tag[a[8:5]][w][22:0] == a[31:9]) return s_tag[a[8:5]][w];
    return '0;
  endfunction

  function automatic logic [31:0] sram_find_word(input logic [31:0] a);
    for (int w = 0; w < 2; w++)
      if (s_tag[a[8:5]][w][24] && s_tag[a[8:5]][w][22:0] == a[31:9])
        return s_data[a[8:5]][w][{a[4:2], 5'd0} +: 32];
    return '0;
  endfunction

  // Off-chip line memory; unwritten lines hold a fixed address-derived pattern.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_3C3C;
  endfunction

  logic [255:0] mem_line [logic [26:0]];

  function automatic logic [255:0] mem_read(input logic [31:0] a);
    logic [255:0] line;
    if (mem_line.exists(a[31:5])) return mem_line[a[31:5]];
    for (int w = 0; w < 8; w++) line[w*32 +: 32] = init_word({a[31:5], 5'd0} + 32'(w * 4));
    return line;
  endfunction

  typedef struct {
    bit           wr;
    logic [31:0]  addr;
    logic [255:0] data;
  } xact_t;

  xact_t log_q[$];
  int    lat_w = 1, lat_r = 1;
  bit    resp_en = 1'b1;
  logic  man_ack = 1'b0;

  // Memory responder: ack arrives in the L-th cycle mem_enable_o is high.
  initial begin
    int rcnt;
    rcnt       = 0;
    mem_ack_i  = 1'b0;
    mem_data_i = '0;
    forever begin
      @(negedge clk_i);
      if (!resp_en) begin
        mem_ack_i  = man_ack;
        mem_data_i = {8{32'hBAD0_BAD0}};
        rcnt       = 0;
      end else begin
        mem_ack_i = 1'b0;
        if (mem_enable_o && rst_i) begin
          rcnt++;
          if (rcnt >= (mem_write_o ? lat_w : lat_r)) begin
            rcnt      = 0;
            mem_ack_i = 1'b1;
            log_q.push_back('{wr: mem_write_o, addr: mem_addr_o, data: mem_data_o});
            if (mem_write_o) mem_line[mem_addr_o[31:5]] = mem_data_o;
            else mem_data_i = mem_read(mem_addr_o);
          end
        end else begin
          rcnt = 0;
        end
      end
    end
  end

  // Reference: architectural word image plus recency-ordered resident lines per set.
  logic [31:0] ref_mem [logic [31:0]];
  bit          dirty_m [logic [26:0]];
  logic [26:0] r0 [16], r1 [16];
  bit          v0 [16] = '{default: 1'b0};
  bit          v1 [16] = '{default: 1'b0};

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_word(a);
  endfunction

  task automatic access(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                        input int lw, input int lr);
    logic [26:0]  la, victim, tmp;
    logic [31:0]  exp_rd;
    logic [255:0] exp_wb;
    int           set, exp_stall, exp_n, stall, k;
    bit           hit, dv, done;
    la     = addr[31:5];
    set    = int'(addr[8:5]);
    hit    = (v0[set] && r0[set] == la) || (v1[set] && r1[set] == la);
    victim = r1[set];
    dv     = !hit && v1[set] && dirty_m.exists(victim) && dirty_m[victim];
    for (int w = 0; w < 8; w++) exp_wb[w*32 +: 32] = ref_read({victim, 5'd0} + 32'(w * 4));
    exp_stall = hit ? 0 : 3 + lr + (dv ? lw : 0);
    exp_n     = hit ? 0 : (dv ? 2 : 1);
    exp_rd    = ref_read(addr);
    if (hit) begin
      if (v1[set] && r1[set] == la) begin
        tmp = r0[set]; r0[set] = r1[set]; r1[set] = tmp;
      end
    end else begin
      r1[set] = r0[set]; v1[set] = v0[set];
      r0[set] = la;      v0[set] = 1'b1;
      dirty_m[la] = 1'b0;
    end
    if (wr) begin
      dirty_m[la]   = 1'b1;
      ref_mem[addr] = wdata;
    end

    lat_w = lw;
    lat_r = lr;
    log_q.delete();
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_write_i = wr;
    cpu_addr_i  = addr;
    cpu_data_i  = wdata;
    stall = 0;
    done  = 1'b0;
    for (int c = 0; c < 100 && !done; c++) begin
      #1;
      if (!cpu_stall_o) begin
        done = 1'b1;
        if (wr) check("store_cpu_data_zero", cpu_data_o, 32'd0);
        else    check("load_data", cpu_data_o, exp_rd);
      end else begin
        stall++;
        @(negedge clk_i);
      end
    end
    check("access_done", done, 1'b1);
    check("stall_cycles", stall, exp_stall);
    @(negedge clk_i);
    cpu_req_i = 1'b0;
    check("mem_xacts", log_q.size(), exp_n);
    if (log_q.size() == exp_n && !hit) begin
      k = 0;
      if (dv) begin
        check("wb_is_write", log_q[0].wr, 1'b1);
        check("wb_addr", log_q[0].addr, {victim, 5'd0});
        check("wb_data", log_q[0].data, exp_wb);
        k = 1;
      end
      check("refill_is_read", log_q[k].wr, 1'b0);
      check("refill_addr", log_q[k].addr, {la, 5'd0});
    end
  endtask

  initial begin
    logic [24:0] snap0, snap1;
    logic [31:0] addr;
    logic [255:0] line;
    bit seen;
    rst_i       = 1'b0;
    cpu_req_i   = 1'b0;
    cpu_write_i = 1'b0;
    cpu_addr_i  = '0;
    cpu_data_i  = '0;
    #2;
    check("rst_mem_enable", mem_enable_o, 1'b0);
    check("rst_mem_write", mem_write_o, 1'b0);
    check("rst_mem_addr", mem_addr_o, 32'd0);
    check("rst_mem_data", mem_data_o, 256'd0);
    check("rst_stall", cpu_stall_o, 1'b0);
    check("rst_sram_enable", sram_enable_o, 1'b0);
    repeat (2) @(negedge clk_i);
    rst_i = 1'b1;

    // Cold load: line 0x40 with word2 = DEADBEEF, L = 4 -> 7 stall cycles.
    line = mem_read(32'h40);
    line[95:64] = 32'hDEAD_BEEF;
    mem_line[27'h2] = line;
    ref_mem[32'h48] = 32'hDEAD_BEEF;
    access(1'b0, 32'h48, 32'h0, 1, 4);
    check("cold_tag_clean", sram_find_tag(32'h40), 25'h100_0000);

    // Store hit into the refilled line.
    access(1'b1, 32'h44, 32'h1234_5678, 1, 1);
    check("store_word1", sram_find_word(32'h44), 32'h1234_5678);
    check("store_dirty_tag", sram_find_tag(32'h40), 25'h180_0000);

    // Fill the other way of set 2, then evict the dirty line 0x40.
    access(1'b0, 32'h2040, 32'h0, 1, 2);
    access(1'b0, 32'h4040, 32'h0, 3, 2);
    access(1'b0, 32'h44, 32'h0, 2, 3);

    // Store miss to a clean set with L = 1 -> 4 stall cycles, then dirty.
    access(1'b1, 32'h60, 32'hCAFE_F00D, 1, 1);
    check("store_miss_dirty", sram_find_tag(32'h60), 25'h180_0000);
    check("store_miss_word", sram_find_word(32'h60), 32'hCAFE_F00D);

    // Reset while waiting for the refill of set 15.
    snap0 = s_tag[15][0];
    snap1 = s_tag[15][1];
    resp_en = 1'b0;
    @(negedge clk_i);
    cpu_req_i   = 1'b1;
    cpu_write_i = 1'b0;
    cpu_addr_i  = 32'h1E0;
    seen = 1'b0;
    for (int c = 0; c < 10 && !seen; c++) begin
      #1;
      if (mem_enable_o) seen = 1'b1;
      else @(negedge clk_i);
    end
    check("rm_enable_seen", seen, 1'b1);
    check("rm_is_read", mem_write_o, 1'b0);
    #1 rst_i = 1'b0;
    #1;
    check("midmiss_rst_enable", mem_enable_o, 1'b0);
    check("midmiss_rst_addr", mem_addr_o, 32'd0);
    man_ack = 1'b1;
    @(negedge clk_i);
    rst_i     = 1'b1;
    cpu_req_i = 1'b0;
    #1 man_ack = 1'b0;
    @(negedge clk_i);
    #1;
    check("late_ack_enable", mem_enable_o, 1'b0);
    check("late_ack_stall", cpu_stall_o, 1'b0);
    check("late_ack_way0", s_tag[15][0], snap0);
    check("late_ack_way1", s_tag[15][1], snap1);
    resp_en = 1'b1;
    access(1'b0, 32'h1E0, 32'h0, 1, 3);

    // Random traffic over 4 sets x 4 tags.
    for (int i = 0; i < 200; i++) begin
      addr = (32'($urandom_range(0, 3)) << 9) | (32'($urandom_range(0, 3)) << 5) |
             (32'($urandom_range(0, 7)) << 2);
      access(1'($urandom_range(0, 1)), addr, $urandom,
             int'($urandom_range(1, 4)), int'($urandom_range(1, 4)));
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
